// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg
//   Shared constants for the two-requester MUX arbiter.
//   - state_t : arbiter FSM encoding (IDLE / GNT0 / GNT1)
//   - SEL_A / SEL_B : MUX select values (0 = data0, 1 = data1)
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_arbiter_mux.sv
// mux2_arbiter_mux
//   Plain DATA_W-wide 2:1 data MUX shared by the two requesters.
//   Ports:
//     sel  : 0 selects a, 1 selects b
//     a, b : data inputs
//     y    : selected data
module mux2_arbiter_mux #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
//   Round-robin arbiter owning the shared 2:1 operand MUX. Each requester
//   raises req_x, receives grant_x, and gives the path back with done_x (or
//   by dropping req_x). A grant held while the other side waits is cut after
//   MAX_HOLD contended cycles so neither side can starve the other.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     req0/req1         : requests (MUX input A / B)
//     done0/done1       : release of a held grant
//     data0/data1       : requester data
//     grant0/grant1     : registered ownership flags (never both high)
//     select            : registered MUX select, holds its value in IDLE
//     out_data          : select ? data1 : data0
//     out_valid         : grant0 | grant1
//
//   Handshake: a request sampled high at a rising edge is granted on that
//   edge; the grant stays until done_x, !req_x or preemption is sampled, and
//   drops on that same edge. done_x is only honoured while x already owns
//   the path. On release with the other side requesting, ownership moves on
//   the same edge, with no overlap and no idle gap.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              done0,
  input  logic              done1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              grant0,
  output logic              grant1,
  output logic              select,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, next_state;
  logic              last, next_last;
  logic              next_select;
  logic [HOLD_W-1:0] hold_cnt, next_hold;
  logic              preempt0, preempt1;

  // Preemption fires on the last allowed contended cycle of a grant.
  assign preempt0 = (hold_cnt == HOLD_LAST) && req1;
  assign preempt1 = (hold_cnt == HOLD_LAST) && req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      select   <= SEL_A;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= next_state;
      select   <= next_select;
      last     <= next_last;
      hold_cnt <= next_hold;
    end
  end

  always_comb begin
    next_state  = state;
    next_select = select;
    next_last   = last;
    next_hold   = hold_cnt;

    case (state)
      IDLE: begin
        // On a tie the requester that was not granted last wins.
        if (req0 && req1)  next_state = last ? GNT0 : GNT1;
        else if (req0)     next_state = GNT0;
        else if (req1)     next_state = GNT1;
      end
      GNT0: begin
        if (done0 || !req0 || preempt0) next_state = req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        if (done1 || !req1 || preempt1) next_state = req0 ? GNT0 : IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (next_state != state) begin
      next_hold = '0;
      if (next_state == GNT0) begin
        next_select = SEL_A;
        next_last   = 1'b0;
      end else if (next_state == GNT1) begin
        next_select = SEL_B;
        next_last   = 1'b1;
      end
    end else if ((state == GNT0 && req1) || (state == GNT1 && req0)) begin
      // Only contended cycles count toward the hold limit.
      next_hold = hold_cnt + 1'b1;
    end
  end

  assign grant0    = (state == GNT0);
  assign grant1    = (state == GNT1);
  assign out_valid = grant0 | grant1;

  mux2_arbiter_mux #(.DATA_W(DATA_W)) u_mux (
    .sel (select),
    .a   (data0),
    .b   (data1),
    .y   (out_data)
  );

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              clk;
  logic              rst_n;
  logic              req0, req1, done0, done1;
  logic [DATA_W-1:0] data0, data1;
  logic              grant0, grant1, select, out_valid;
  logic [DATA_W-1:0] out_data;

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux2_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .done0     (done0),
    .done1     (done1),
    .data0     (data0),
    .data1     (data1),
    .grant0    (grant0),
    .grant1    (grant1),
    .select    (select),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; done0 = 1'b0; done1 = 1'b0;
    data0 = 8'h11; data1 = 8'h22;
    #23;
    checks++;
    if (grant0 !== 1'b0 || grant1 !== 1'b0) begin
      errors++; $display("FAIL reset_grants: got %b%b expected 00", grant0, grant1);
    end
    checks++;
    if (select !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_sel_valid: got sel=%b valid=%b expected 0 0", select, out_valid);
    end
    checks++;
    if (out_data !== 8'h11) begin
      errors++; $display("FAIL reset_out_data: got %h expected 11", out_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant0 !== 1'b1 || grant1 !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_tie: got g0=%b g1=%b v=%b expected 1 0 1", grant0, grant1, out_valid);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_single();
    req1 = 1'b1; data1 = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant1 !== 1'b1 || grant0 !== 1'b0 || select !== 1'b1 || out_data !== 8'hA5) begin
        errors++; $display("FAIL single_hold[%0d]: got g1=%b g0=%b sel=%b data=%h expected 1 0 1 a5",
                           i, grant1, grant0, select, out_data);
      end
    end
    done1 = 1'b1;
    tick();
    checks++;
    if (grant1 !== 1'b0 || out_valid !== 1'b0 || select !== 1'b1) begin
      errors++; $display("FAIL single_done_release: got g1=%b v=%b sel=%b expected 0 0 1", grant1, out_valid, select);
    end
    done1 = 1'b0;
    tick();
    checks++;
    if (grant1 !== 1'b1) begin
      errors++; $display("FAIL single_regrant: got g1=%b expected 1", grant1);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_handover();
    data0 = 8'h3C; data1 = 8'hC3;
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    tick();
    checks++;
    if (grant0 !== 1'b1 || grant1 !== 1'b0 || select !== 1'b0 || out_data !== 8'h3C) begin
      errors++; $display("FAIL handover_before: got g0=%b g1=%b sel=%b data=%h expected 1 0 0 3c",
                         grant0, grant1, select, out_data);
    end
    done0 = 1'b1;
    tick();
    checks++;
    if (grant0 !== 1'b0 || grant1 !== 1'b1 || select !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hC3) begin
      errors++; $display("FAIL handover_switch: got g0=%b g1=%b sel=%b v=%b data=%h expected 0 1 1 1 c3",
                         grant0, grant1, select, out_valid, out_data);
    end
    done0 = 1'b0; req0 = 1'b0;
    tick();
    req1 = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL handover_idle: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_preempt();
    int owner;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      owner = (k / MAX_HOLD) % 2;
      checks++;
      if (grant0 !== (owner == 0) || grant1 !== (owner == 1) || select !== owner[0] || out_valid !== 1'b1) begin
        errors++; $display("FAIL preempt[%0d]: got g0=%b g1=%b sel=%b v=%b expected owner %0d",
                           k, grant0, grant1, select, out_valid, owner);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL preempt_idle: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_tie();
    // Make requester 0 the last one granted.
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if (grant1 !== 1'b1 || grant0 !== 1'b0) begin
      errors++; $display("FAIL tie_first: got g0=%b g1=%b expected 0 1", grant0, grant1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if (grant0 !== 1'b1 || grant1 !== 1'b0) begin
      errors++; $display("FAIL tie_second: got g0=%b g1=%b expected 1 0", grant0, grant1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_stray_done_reset();
    // done0 on the granting edge is ignored.
    req0 = 1'b1; done0 = 1'b1;
    tick();
    done0 = 1'b0;
    tick();
    checks++;
    if (grant0 !== 1'b1) begin
      errors++; $display("FAIL done_on_grant_edge: got g0=%b expected 1", grant0);
    end
    req0 = 1'b0;
    tick();
    req1 = 1'b1;
    tick();
    done0 = 1'b1;
    tick();
    checks++;
    if (grant1 !== 1'b1 || grant0 !== 1'b0 || select !== 1'b1) begin
      errors++; $display("FAIL stray_done0: got g0=%b g1=%b sel=%b expected 0 1 1", grant0, grant1, select);
    end
    done0 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant1 !== 1'b0 || select !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got g1=%b sel=%b v=%b expected 0 0 0", grant1, select, out_valid);
    end
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant1 !== 1'b1 || select !== 1'b1) begin
      errors++; $display("FAIL reset_regrant: got g1=%b sel=%b expected 1 1", grant1, select);
    end
    req1 = 1'b0;
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_handover();
    test_preempt();
    test_tie();
    test_stray_done_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
